mmul2_index_sequencer: RTL and testbench

Control block for the `mmul2` matrix multiplier. It validates the static matrix dimensions and generates the (i, j, k) multiply-accumulate index sequence for C = A·B, one index triple per enabled cycle. It also produces a sticky completion flag. The datapath consumes the indices and strobes; it owns the A/B/C storage and arithmetic.

---
 rtl/mmul2_pkg.sv | 32 +++
 rtl/mmul2_dim_check.sv | 15 +
 rtl/mmul2_index_sequencer.sv | 93 +++++++++
 tb/tb_mmul2_index_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mmul2_pkg.sv
// rtl/mmul2_pkg.sv - constant functions and state encoding shared by the mmul2 control path
package mmul2_pkg;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  // Smallest r with 2**r >= v; 0 and 1 both map to 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < v) r = b + 1;
    end
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Index width for an RA x CA by RB x CB product; never narrower than one bit.
  function automatic int idx_width(input int ra, input int ca, input int cb);
    int w;
    w = clog2(max3(ra, ca, cb));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mmul2_dim_check.sv
// rtl/mmul2_dim_check.sv - combinational legality check of the static matrix dimensions
module mmul2_dim_check
  import mmul2_pkg::*;
#(
  parameter int RA = 1,
  parameter int CA = 1,
  parameter int RB = 1,
  parameter int CB = 1
) (
  output logic valid
);

  assign valid = (CA == RB) && (RA >= 1) && (CA >= 1) && (RB >= 1) && (CB >= 1);

endmodule

// File: rtl/mmul2_index_sequencer.sv
// rtl/mmul2_index_sequencer.sv - generates the (i, j, k) MAC index sequence and sticky done for mmul2
module mmul2_index_sequencer
  import mmul2_pkg::*;
#(
  parameter int  RA = 1,
  parameter int  CA = 1,
  parameter int  RB = 1,
  parameter int  CB = 1,
  localparam int IW = idx_width(RA, CA, CB)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          valid,
  output logic          step,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic [IW-1:0] k,
  output logic          acc_first,
  output logic          acc_last,
  output logic          done
);

  typedef logic [IW-1:0] idx_t;

  // Terminal counts; illegal (zero) dimensions clamp to 0 and never matter since step stays low.
  localparam idx_t I_LAST = IW'((RA >= 1) ? RA - 1 : 0);
  localparam idx_t J_LAST = IW'((CB >= 1) ? CB - 1 : 0);
  localparam idx_t K_LAST = IW'((CA >= 1) ? CA - 1 : 0);

  idx_t       i_q, i_d;
  idx_t       j_q, j_d;
  idx_t       k_q, k_d;
  logic [0:0] state_q, state_d;

  mmul2_dim_check #(
    .RA(RA),
    .CA(CA),
    .RB(RB),
    .CB(CB)
  ) u_dim_check (
    .valid(valid)
  );

  assign step      = enable && valid && (state_q == ST_RUN) && !rst;
  assign acc_first = step && (k_q == '0);
  assign acc_last  = step && (k_q == K_LAST);
  assign done      = (state_q == ST_DONE);
  assign i         = i_q;
  assign j         = j_q;
  assign k         = k_q;

  // Counters stay within [0, LAST], so a not-equal test is the same as "below last".
  always_comb begin
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    state_d = state_q;
    if (step) begin
      if (k_q != K_LAST) begin
        k_d = k_q + 1'b1;
      end else begin
        k_d = '0;
        if (j_q != J_LAST) begin
          j_d = j_q + 1'b1;
        end else begin
          j_d = '0;
          if (i_q != I_LAST) begin
            i_d = i_q + 1'b1;
          end else begin
            i_d     = '0;
            state_d = ST_DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      state_q <= ST_RUN;
    end else begin
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_mmul2_index_sequencer.sv
// tb/tb_mmul2_index_sequencer.sv - self-checking bench for mmul2_index_sequencer
module tb_mmul2_index_sequencer;

  localparam int A_RA = 2;
  localparam int A_CA = 3;
  localparam int A_CB = 2;
  localparam int A_N  = A_RA * A_CB * A_CA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: 2x3 times 3x2
  logic       rst_a = 1'b1, en_a = 1'b0;
  logic       va, sa, afa, ala, da;
  logic [1:0] ia, ja, ka;
  // Instance B: 2x3 times 2x2 (inner mismatch)
  logic       rst_b = 1'b1, en_b = 1'b0;
  logic       vb, sb, afb, alb, db;
  logic [1:0] ib, jb, kb;
  // Instance C: 1x1 times 1x1
  logic       rst_c = 1'b1, en_c = 1'b0;
  logic       vc, sc, afc, alc, dc;
  logic [0:0] ic, jc, kc;
  // Instance D: CB = 0
  logic       rst_d = 1'b1, en_d = 1'b0;
  logic       vd, sd, afd, ald, dd;
  logic [1:0] id, jd, kd;

  mmul2_index_sequencer #(.RA(2), .CA(3), .RB(3), .CB(2)) dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .valid(va), .step(sa), .i(ia), .j(ja), .k(ka),
    .acc_first(afa), .acc_last(ala), .done(da));
  mmul2_index_sequencer #(.RA(2), .CA(3), .RB(2), .CB(2)) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .valid(vb), .step(sb), .i(ib), .j(jb), .k(kb),
    .acc_first(afb), .acc_last(alb), .done(db));
  mmul2_index_sequencer #(.RA(1), .CA(1), .RB(1), .CB(1)) dut_c (
    .clk(clk), .rst(rst_c), .enable(en_c), .valid(vc), .step(sc), .i(ic), .j(jc), .k(kc),
    .acc_first(afc), .acc_last(alc), .done(dc));
  mmul2_index_sequencer #(.RA(2), .CA(3), .RB(3), .CB(0)) dut_d (
    .clk(clk), .rst(rst_d), .enable(en_d), .valid(vd), .step(sd), .i(id), .j(jd), .k(kd),
    .acc_first(afd), .acc_last(ald), .done(dd));

  // Reference model for instance A: n_a = number of MACs already issued this run.
  int         n_a = 0;
  logic       prev_rst = 1'b0, prev_step = 1'b0;
  logic       exp_step, exp_done, exp_af, exp_al;
  logic [5:0] exp_t;

  function automatic logic [5:0] a_triple(input int n);
    if (n >= A_N) return 6'd0;
    return {2'(n / (A_CB * A_CA)), 2'((n / A_CA) % A_CB), 2'(n % A_CA)};
  endfunction

  // Applies the previous edge to the model, drives this cycle's inputs, and forms expectations.
  task automatic a_drive(input logic r, input logic e);
    @(negedge clk);
    if (prev_rst) n_a = 0;
    else if (prev_step) n_a++;
    rst_a = r;
    en_a  = e;
    #1;
    exp_t     = a_triple(n_a);
    exp_step  = !r && e && (n_a < A_N);
    exp_done  = (n_a >= A_N);
    exp_af    = exp_step && (exp_t[1:0] == 2'd0);
    exp_al    = exp_step && (exp_t[1:0] == 2'(A_CA - 1));
    prev_rst  = r;
    prev_step = exp_step;
  endtask

  task automatic test_reset();
    a_drive(1'b1, 1'b0);
    a_drive(1'b1, 1'b1);
    checks++; if (va !== 1'b1) begin failures++; $display("FAIL reset_valid got=%b exp=1", va); end
    checks++; if (sa !== 1'b0) begin failures++; $display("FAIL reset_step got=%b exp=0", sa); end
    checks++; if ({ia, ja, ka} !== 6'd0) begin failures++; $display("FAIL reset_ijk got=%h exp=0", {ia, ja, ka}); end
    checks++; if (da !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", da); end
    checks++; if ({afa, ala} !== 2'b00) begin failures++; $display("FAIL reset_acc got=%b exp=00", {afa, ala}); end
  endtask

  task automatic test_full_sequence();
    int steps;
    steps = 0;
    a_drive(1'b1, 1'b0);
    for (int c = 0; c < 16; c++) begin
      a_drive(1'b0, 1'b1);
      if (sa === 1'b1) steps++;
      checks++; if (sa !== (c < 12)) begin failures++; $display("FAIL full_step c=%0d got=%b exp=%b", c, sa, (c < 12)); end
      checks++; if (da !== (c >= 12)) begin failures++; $display("FAIL full_done c=%0d got=%b exp=%b", c, da, (c >= 12)); end
      checks++; if (afa !== (c < 12 && c % 3 == 0)) begin failures++; $display("FAIL full_acc_first c=%0d got=%b", c, afa); end
      checks++; if (ala !== (c < 12 && c % 3 == 2)) begin failures++; $display("FAIL full_acc_last c=%0d got=%b", c, ala); end
      checks++; if ({ia, ja, ka} !== exp_t) begin failures++; $display("FAIL full_ijk c=%0d got=%h exp=%h", c, {ia, ja, ka}, exp_t); end
    end
    checks++; if (steps != 12) begin failures++; $display("FAIL full_count got=%0d exp=12", steps); end
  endtask

  task automatic test_pause();
    int first_done;
    first_done = -1;
    a_drive(1'b1, 1'b0);
    for (int c = 0; c < 22; c++) begin
      a_drive(1'b0, !(c >= 4 && c < 9));
      if (da === 1'b1 && first_done < 0) first_done = c;
      checks++; if (sa !== exp_step) begin failures++; $display("FAIL pause_step c=%0d got=%b exp=%b", c, sa, exp_step); end
      checks++; if ({ia, ja, ka} !== exp_t) begin failures++; $display("FAIL pause_ijk c=%0d got=%h exp=%h", c, {ia, ja, ka}, exp_t); end
      if (c >= 4 && c < 9) begin
        checks++; if ({ia, ja, ka} !== {2'd0, 2'd1, 2'd1}) begin failures++; $display("FAIL pause_hold c=%0d got=%h exp=05", c, {ia, ja, ka}); end
      end
    end
    checks++; if (first_done != 17) begin failures++; $display("FAIL pause_done_cycle got=%0d exp=17", first_done); end
  endtask

  task automatic test_reset_mid_run();
    int steps;
    steps = 0;
    a_drive(1'b1, 1'b0);
    for (int c = 0; c < 7; c++) a_drive(1'b0, 1'b1);
    a_drive(1'b1, 1'b1);
    checks++; if (sa !== 1'b0) begin failures++; $display("FAIL midrst_step got=%b exp=0", sa); end
    checks++; if ({ia, ja, ka} !== {2'd1, 2'd0, 2'd1}) begin failures++; $display("FAIL midrst_held got=%h exp=11", {ia, ja, ka}); end
    for (int c = 0; c < 14; c++) begin
      a_drive(1'b0, 1'b1);
      if (c == 0) begin
        checks++; if ({ia, ja, ka, da, sa} !== 8'b0000_0001) begin failures++; $display("FAIL midrst_restart got=%b exp=00000001", {ia, ja, ka, da, sa}); end
      end
      if (sa === 1'b1) steps++;
      checks++; if ({ia, ja, ka} !== exp_t) begin failures++; $display("FAIL midrst_ijk c=%0d got=%h exp=%h", c, {ia, ja, ka}, exp_t); end
    end
    checks++; if (steps != 12) begin failures++; $display("FAIL midrst_count got=%0d exp=12", steps); end
    checks++; if (da !== 1'b1) begin failures++; $display("FAIL midrst_done got=%b exp=1", da); end
  endtask

  task automatic test_random_enable();
    logic r, e;
    a_drive(1'b1, 1'b0);
    for (int c = 0; c < 200; c++) begin
      r = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 3) != 0);
      a_drive(r, e);
      checks++;
      if ({sa, afa, ala, da, ia, ja, ka} !== {exp_step, exp_af, exp_al, exp_done, exp_t}) begin
        failures++;
        $display("FAIL random c=%0d got=%b exp=%b", c, {sa, afa, ala, da, ia, ja, ka},
                 {exp_step, exp_af, exp_al, exp_done, exp_t});
      end
    end
  endtask

  task automatic test_unit_dims();
    @(negedge clk); rst_c = 1'b1; en_c = 1'b1;
    @(negedge clk); rst_c = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (vc !== 1'b1) begin failures++; $display("FAIL unit_valid got=%b exp=1", vc); end
      checks++; if ({sc, afc, alc} !== {3{c == 0}}) begin failures++; $display("FAIL unit_step c=%0d got=%b", c, {sc, afc, alc}); end
      checks++; if (dc !== (c >= 1)) begin failures++; $display("FAIL unit_done c=%0d got=%b exp=%b", c, dc, (c >= 1)); end
      checks++; if ({ic, jc, kc} !== 3'd0) begin failures++; $display("FAIL unit_ijk c=%0d got=%b exp=000", c, {ic, jc, kc}); end
      @(negedge clk);
    end
  endtask

  task automatic test_invalid_dims();
    @(negedge clk); rst_b = 1'b1; rst_d = 1'b1; en_b = 1'b1; en_d = 1'b1;
    @(negedge clk); rst_b = 1'b0; rst_d = 1'b0;
    for (int c = 0; c < 50; c++) begin
      #1;
      checks++;
      if ({vb, sb, afb, alb, db, ib, jb, kb} !== 11'd0) begin
        failures++; $display("FAIL inner_mismatch c=%0d got=%b exp=0", c, {vb, sb, afb, alb, db, ib, jb, kb});
      end
      checks++;
      if ({vd, sd, afd, ald, dd, id, jd, kd} !== 11'd0) begin
        failures++; $display("FAIL cb_zero c=%0d got=%b exp=0", c, {vd, sd, afd, ald, dd, id, jd, kd});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_pause();
    test_reset_mid_run();
    test_random_enable();
    test_unit_dims();
    test_invalid_dims();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
